// File: rtl/spi_sram_bridge.sv
// -----------------------------------------------------------------------------
// spi_sram_bridge
//
// Purpose:
//   Converts single-byte CPU memory requests into 23LC512-style serial SRAM
//   transactions: opcode (READ/WRITE), then address, then one data byte, all
//   MSB first. SCLK is the free-running system clk, forwarded outside this
//   block. When an incrementing, same-direction request arrives in the last
//   bit cycle of a byte, chip select stays low and only the next data byte is
//   transferred (SRAM sequential mode).
//
// Ports:
//   clk        system clock, also the SCLK seen by the SRAM
//   rst_n      asynchronous active-low reset
//   req_valid  request present; payload held stable until accepted
//   req_ready  request accepted on a posedge where req_valid & req_ready
//   req_we     1 = write, 0 = read
//   req_addr   byte address (ADDR_W bits)
//   req_wdata  write data
//   rsp_valid  one-cycle pulse: read data valid or write completed
//   rsp_rdata  read data, holds its last value otherwise
//   busy       high from accept until spi_cs_n has been seen high again
//   spi_cs_n   SRAM chip select, active low (negedge launched)
//   spi_mosi   serial data to SRAM (negedge launched)
//   spi_miso   serial data from SRAM (sampled on posedge)
// -----------------------------------------------------------------------------
module spi_sram_bridge #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CS_GAP = 1,
    parameter int unsigned SEQ_EN = 1,
    parameter logic [7:0]  RD_CMD = 8'h03,
    parameter logic [7:0]  WR_CMD = 8'h02
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int unsigned N     = 16 + ADDR_W;
    localparam int unsigned CNT_W = 5;
    // Gap counter holds CS_GAP-1 down to 0.
    localparam int unsigned GAP_W = (CS_GAP > 2) ? $clog2(CS_GAP) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [N-1:0]        sr_q, sr_d;
    logic [7:0]          rx_q, rx_d;
    logic                cur_we_q, cur_we_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [7:0]          rsp_rdata_q, rsp_rdata_d;
    logic                busy_q, busy_d;
    logic                ready_en_q;
    logic                cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;

    logic                active;
    logic                last_bit;
    logic                seq_ok;
    logic                accept;
    logic [ADDR_W-1:0]   next_addr;

    assign active    = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign last_bit  = (state_q == ST_DATA) && (cnt_q == CNT_W'(7));
    assign next_addr = cur_addr_q + ADDR_W'(1);

    // Continuation is decided combinationally from the live request so the
    // next byte can start on the very edge that ends the current one.
    assign seq_ok    = (SEQ_EN != 0) && last_bit && req_valid &&
                       (req_we == cur_we_q) && (req_addr == next_addr);
    assign req_ready = ready_en_q && ((state_q == ST_IDLE) || seq_ok);
    assign accept    = req_valid && req_ready;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_mosi  = mosi_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        sr_d        = sr_q;
        rx_d        = rx_q;
        cur_we_d    = cur_we_q;
        cur_addr_d  = cur_addr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        busy_d      = busy_q;

        if (active) begin
            sr_d = {sr_q[N-2:0], 1'b0};
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sr_d       = {(req_we ? WR_CMD : RD_CMD), req_addr, req_wdata};
                    cur_we_d   = req_we;
                    cur_addr_d = req_addr;
                    cnt_d      = '0;
                    state_d    = ST_CMD;
                end
            end
            ST_CMD: begin
                if (cnt_q == CNT_W'(7)) begin
                    cnt_d   = '0;
                    state_d = ST_ADDR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ADDR: begin
                if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                // miso is valid at every data-phase rising edge; the final
                // sample is merged directly into the response byte.
                rx_d = {rx_q[6:0], spi_miso};
                if (cnt_q == CNT_W'(7)) begin
                    rsp_valid_d = 1'b1;
                    if (!cur_we_q) begin
                        rsp_rdata_d = {rx_q[6:0], spi_miso};
                    end
                    if (seq_ok) begin
                        sr_d       = '0;
                        sr_d[N-1 -: 8] = req_wdata;
                        cur_addr_d = req_addr;
                        cnt_d      = '0;
                    end else begin
                        gap_d   = GAP_W'(CS_GAP - 1);
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            busy_d = 1'b1;
        end else if ((state_q == ST_GAP) && cs_n_q) begin
            busy_d = 1'b0;
        end

        // Pin values launched on the falling edge from current posedge state.
        cs_n_d = !active;
        mosi_d = active ? sr_q[N-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gap_q       <= '0;
            sr_q        <= '0;
            rx_q        <= '0;
            cur_we_q    <= 1'b0;
            cur_addr_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            sr_q        <= sr_d;
            rx_q        <= rx_d;
            cur_we_q    <= cur_we_d;
            cur_addr_q  <= cur_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            ready_en_q  <= 1'b1;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
        end else begin
            cs_n_q <= cs_n_d;
            mosi_q <= mosi_d;
        end
    end

endmodule

// File: tb/tb_spi_sram_bridge.sv
module tb_spi_sram_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        spi_miso = 1'b0;

    logic        rdy_a, rdy_b, rv_a, rv_b, busy_a, busy_b;
    logic        cs_a, cs_b, mosi_a, mosi_b;
    logic [7:0]  rd_a, rd_b;

    logic        req_ready, rsp_valid, busy, spi_cs_n, spi_mosi;
    logic [7:0]  rsp_rdata;

    always #5 clk = ~clk;

    spi_sram_bridge #(.ADDR_W(16), .CS_GAP(3), .SEQ_EN(1), .RD_CMD(8'h03), .WR_CMD(8'h02)) u_dut_seq (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(rdy_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv_a), .rsp_rdata(rd_a), .busy(busy_a),
        .spi_cs_n(cs_a), .spi_mosi(mosi_a), .spi_miso(spi_miso)
    );

    spi_sram_bridge #(.ADDR_W(16), .CS_GAP(3), .SEQ_EN(0), .RD_CMD(8'h03), .WR_CMD(8'h02)) u_dut_noseq (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rdy_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv_b), .rsp_rdata(rd_b), .busy(busy_b),
        .spi_cs_n(cs_b), .spi_mosi(mosi_b), .spi_miso(spi_miso)
    );

    assign req_ready = sel ? rdy_b : rdy_a;
    assign rsp_valid = rv_a | rv_b;
    assign rsp_rdata = sel ? rd_b : rd_a;
    assign busy      = sel ? busy_b : busy_a;
    assign spi_cs_n  = cs_a & cs_b;
    assign spi_mosi  = cs_a ? mosi_b : mosi_a;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic we; logic [7:0] rd; int at; } rsp_t;
    typedef struct { logic [31:0] bits; logic is_rd; } frm_t;
    rsp_t sb[$];
    frm_t fq[$];
    logic [7:0] last_rd = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Response monitor: pops one expectation per rsp_valid pulse.
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid rdata %0h, required no response", rsp_rdata);
            end else begin
                e = sb.pop_front();
                check("rsp_cycle", cyc, e.at);
                if (e.we) begin
                    check("rsp_rdata_hold", rsp_rdata, last_rd);
                end else begin
                    check("rsp_rdata", rsp_rdata, e.rd);
                    last_rd = e.rd;
                end
            end
        end
    end
    always @(negedge rst_n) last_rd = 8'h00;

    // Chip-select window tracker: counts frames and checks the high gap.
    int cs_falls = 0;
    int hi_cnt = 0;
    bit seen = 1'b0;
    logic cs_prev = 1'b1;
    always @(posedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
            hi_cnt = 0;
        end else if (spi_cs_n) begin
            hi_cnt++;
        end else if (cs_prev) begin
            cs_falls++;
            if (seen) begin
                checks++;
                if (hi_cnt < 3) begin
                    errors++;
                    $display("FAIL cs_gap: got %0d high cycles, required >= 3", hi_cnt);
                end
            end
            seen = 1'b1;
            hi_cnt = 0;
        end
        cs_prev = spi_cs_n;
    end

    // Serial SRAM model (16-bit address, sequential mode).
    logic [7:0]  mem [0:65535];
    int          bc = 0;
    logic [7:0]  op = '0;
    logic [15:0] base = '0;
    logic [31:0] cap = '0;
    logic [7:0]  wsh = '0;
    always @(posedge clk) begin
        frm_t f;
        if (spi_cs_n) begin
            bc = 0;
        end else begin
            if (bc < 32) cap = {cap[30:0], spi_mosi};
            if (bc < 8) begin
                op = {op[6:0], spi_mosi};
            end else if (bc < 24) begin
                base = {base[14:0], spi_mosi};
            end else if (op == 8'h02) begin
                wsh = {wsh[6:0], spi_mosi};
                if ((bc - 24) % 8 == 7) mem[base + 16'((bc - 24) / 8)] = wsh;
            end
            bc++;
            if (bc == 32) begin
                if (fq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got %0h, required no frame", cap);
                end else begin
                    f = fq.pop_front();
                    if (f.is_rd) check("frame_rd", {8'h00, cap[31:8]}, {8'h00, f.bits[31:8]});
                    else         check("frame_wr", cap, f.bits);
                end
            end
        end
    end
    always @(negedge clk) begin
        logic [7:0] b;
        if (!spi_cs_n && bc >= 24 && op == 8'h03) begin
            b = mem[base + 16'((bc - 24) / 8)];
            spi_miso = b[3'(7 - ((bc - 24) % 8))];
        end else begin
            spi_miso = 1'b0;
        end
    end

    task automatic issue(input logic we, input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] exp, input int lat, input bit new_frame,
                         input int exp_acc, output int acc);
        int t;
        rsp_t r;
        frm_t f;
        t = 0;
        acc = -1;
        @(negedge clk);
        req_we = we;
        req_addr = a;
        req_wdata = d;
        req_valid = 1'b1;
        #1;
        while (!req_ready && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no req_ready for addr %0h, required accept", a);
            req_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        r.we = we;
        r.rd = exp;
        r.at = acc + lat;
        sb.push_back(r);
        if (new_frame) begin
            f.bits = {(we ? 8'h02 : 8'h03), a, d};
            f.is_rd = !we;
            fq.push_back(f);
        end
        if (exp_acc >= 0) check("accept_cycle", acc, exp_acc);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || fq.size() != 0 || !spi_cs_n || busy) && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 400) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses, required 0", sb.size());
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got simulation time limit, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int k, k2, k3, f0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1234] = 8'hA5;
        mem[16'hFFFE] = 8'h11;
        mem[16'hFFFF] = 8'h22;
        mem[16'h0000] = 8'h33;
        mem[16'h1000] = 8'h44;
        mem[16'h2000] = 8'h55;
        mem[16'h0042] = 8'h66;

        // Reset and idle
        repeat (3) @(negedge clk);
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_mosi", spi_mosi, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", req_ready, 1);
        f0 = cs_falls;
        repeat (100) @(negedge clk);
        check("idle_no_cs", cs_falls, f0);
        check("idle_cs_n", spi_cs_n, 1);

        // Single read 0x1234 -> 0xA5, busy edge timing
        issue(1'b0, 16'h1234, 8'h00, 8'hA5, 32, 1'b1, -1, k);
        check("busy_after_accept", busy, 1);
        repeat (32) @(posedge clk);
        #1;
        check("busy_last_bit", busy, 1);
        @(posedge clk);
        #1;
        check("busy_fall", busy, 0);
        drain();

        // Write 0xBEEF <- 0x5A, then read it back
        issue(1'b1, 16'hBEEF, 8'h5A, 8'h00, 32, 1'b1, -1, k);
        issue(1'b0, 16'hBEEF, 8'h00, 8'h5A, 32, 1'b1, k + 36, k2);
        drain();

        // Sequential reads with wrap, continuation enabled
        f0 = cs_falls;
        issue(1'b0, 16'hFFFE, 8'h00, 8'h11, 32, 1'b1, -1, k);
        issue(1'b0, 16'hFFFF, 8'h00, 8'h22, 8, 1'b0, k + 32, k2);
        issue(1'b0, 16'h0000, 8'h00, 8'h33, 8, 1'b0, k2 + 8, k3);
        drain();
        check("seq_cs_windows", cs_falls - f0, 1);

        // Same sequence on the instance without continuation
        @(negedge clk);
        sel = 1'b1;
        f0 = cs_falls;
        issue(1'b0, 16'hFFFE, 8'h00, 8'h11, 32, 1'b1, -1, k);
        issue(1'b0, 16'hFFFF, 8'h00, 8'h22, 32, 1'b1, k + 36, k2);
        issue(1'b0, 16'h0000, 8'h00, 8'h33, 32, 1'b1, k2 + 36, k3);
        drain();
        check("noseq_cs_windows", cs_falls - f0, 3);
        sel = 1'b0;

        // Non-matching follow-ups presented during the last bit
        issue(1'b0, 16'h1000, 8'h00, 8'h44, 32, 1'b1, -1, k);
        issue(1'b1, 16'h1001, 8'h77, 8'h00, 32, 1'b1, k + 36, k2);
        issue(1'b0, 16'h1000, 8'h00, 8'h44, 32, 1'b1, k2 + 36, k3);
        issue(1'b0, 16'h2000, 8'h00, 8'h55, 32, 1'b1, k3 + 36, k);
        issue(1'b0, 16'h1001, 8'h00, 8'h77, 32, 1'b1, k + 36, k2);
        drain();

        // Reset during the address phase
        @(negedge clk);
        req_we = 1'b0;
        req_addr = 16'h1000;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (12) @(posedge clk);
        check("pre_reset_cs_low", spi_cs_n, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cs_n", spi_cs_n, 1);
        check("async_rst_rsp_valid", rsp_valid, 0);
        check("async_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(1'b0, 16'h0042, 8'h00, 8'h66, 32, 1'b1, -1, k);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_sram_bridge.md
Name: spi_sram_bridge

Overview:
- Bus-to-SPI master that turns single-byte CPU memory requests into 23LC512-style serial SRAM transactions: READ 0x03 or WRITE 0x02, then address, then data, all MSB first.
- Sits directly upstream of the chip's SPI pins, between the 6502 core's memory request port and spi_cs_n/spi_mosi/spi_miso.
- SCLK is the free-running system clk, forwarded at top level; this block never gates it.
- Supports sequential-mode continuation: an incrementing same-direction request keeps CS low and skips command/address.

Parameters:
- ADDR_W, 16, SRAM address width in bits; legal values 16 or 24.
- CS_GAP, 1, minimum number of clk cycles spi_cs_n stays high between transactions (>=1).
- SEQ_EN, 1, 1 enables sequential continuation; 0 makes every request a full transaction.
- RD_CMD, 8'h03, read opcode.
- WR_CMD, 8'h02, write opcode.

Ports:
- clk  input  1  system clock, also the SPI SCLK seen by the SRAM.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present; must hold stable with its payload until accepted.
- req_ready  output  1  request accepted on a posedge where req_valid&req_ready.
- req_we  input  1  1=write, 0=read.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  8  write data.
- rsp_valid  output  1  one-cycle pulse: read data valid, or write completed.
- rsp_rdata  output  8  read data; holds its last value otherwise.
- busy  output  1  high from accept until spi_cs_n has returned high.
- spi_cs_n  output  1  SRAM chip select, active low.
- spi_mosi  output  1  serial data to SRAM.
- spi_miso  input  1  serial data from SRAM.

Behaviour:
- Clocking: FSM, counters and miso sampling use posedge clk. spi_cs_n and spi_mosi come from negedge-clocked flops, so they are stable at every SRAM sampling rising edge.
- Reset: all of the following are async.
  - spi_cs_n=1, spi_mosi=0.
  - rsp_valid=0, rsp_rdata=0, busy=0.
  - FSM=IDLE, CS_GAP counter treated as expired.
  - req_ready=1 from the first posedge after deassertion.
- States: IDLE -> CMD (8 bits) -> ADDR (ADDR_W bits) -> DATA (8 bits) -> GAP -> IDLE.
- Shift register: one bit per clk. Loaded on accept with {opcode, addr, wdata}.
- Timing: let accept occur at posedge k and N = 16+ADDR_W.
  - At negedge k: cs_n falls and mosi=opcode[7].
  - The SRAM samples bit i at posedge k+1+i.
  - Read: miso is sampled at posedges k+N-7..k+N. rsp_rdata is updated and rsp_valid=1 in the cycle following posedge k+N. For ADDR_W=16, latency is 32 clk.
  - Write: wdata is shifted at the same positions. The rsp_valid pulse has identical timing; rsp_rdata is unchanged.
- Continuation, only when SEQ_EN=1: in the LAST_BIT cycle (the cycle ending at posedge k+N), req_ready=req_valid & (req_we==cur_we) & (req_addr==cur_addr+1 mod 2^ADDR_W).
  - This combinational dependence of ready on valid is intended.
  - If accepted: cs_n stays low, no opcode or address is sent, and the next data byte follows immediately.
  - The next rsp_valid comes 8 clk after the previous one.
  - 0xFFFF -> 0x0000 wrap is a legal match, mirroring SRAM sequential wrap.
- Otherwise in LAST_BIT: req_ready=0.
  - At negedge k+N, cs_n rises and mosi=0.
  - GAP holds cs_n high for CS_GAP cycles, with ready=0; then IDLE with ready=1.
- Read continuation is required because SCLK is free running: with cs_n low, the SRAM keeps advancing, so cs_n must never stay low without a byte being consumed.
- busy falls the cycle cs_n is observed high at posedge.
- req_ready is 0 in CMD, ADDR, DATA (except LAST_BIT) and GAP.
- Reset mid-transaction: cs_n rises immediately and asynchronously, with no rsp_valid. The partial transfer is discarded, and the next request starts a full command.

Test Plan:
- Reset/idle: hold rst_n=0 then release -> spi_cs_n=1, spi_mosi=0, rsp_valid=0, req_ready=1; no cs_n activity with req_valid=0 for 100 cycles.
- Single read 0x1234, SRAM model returns 0xA5 -> mosi bits 03,12,34 at posedges k+1..k+24; rsp_valid one cycle after posedge k+32 with rsp_rdata=0xA5; cs_n high >=CS_GAP cycles after.
- Write 0xBEEF<-0x5A then read 0xBEEF -> mosi stream 02 BE EF 5A; write rsp_valid at +32; read returns 0x5A.
- Sequential reads 0xFFFE, 0xFFFF, 0x0000, SEQ_EN=1, each presented at LAST_BIT -> single cs_n low window, one opcode, rsp_valid at +32, +40, +48. With SEQ_EN=0 -> three separate 32-cycle transactions with gaps.
- Non-matching follow-ups at LAST_BIT (read 0x2000 after read 0x1000; write 0x1001 after read 0x1000) -> req_ready=0, cs_n rises, CS_GAP=3 honoured, then full new transaction.
- rst_n pulsed low during ADDR phase -> cs_n=1 asynchronously, no rsp_valid; next read 0x0042 completes normally in 32 clk.
